axi4lite_reg_bridge: RTL and testbench
======================================

Name: axi4lite_reg_bridge

Overview:
- Parametrised AXI4-Lite slave endpoint with flattened ports. Converts AXI4-Lite read and write transactions into a single-cycle register-bank strobe bus for the timer regblock.
- Adds the following:
  - independent AW/W capture buffers;
  - QoS-based read/write arbitration with round-robin tie-break;
  - address range checking;
  - 2-bit OKAY/SLVERR responses.
- Sits between the interconnect and the timer register file.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; 32 or 64 only. STRB_WIDTH = DATA_WIDTH/8. ADDR_LSB = log2(STRB_WIDTH).
- REG_NUM, 16, number of implemented words. Legal word index is 0..REG_NUM-1.
- QOS_EN, 1, when 1, QoS decides read/write priority. When 0, only round-robin is used.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- ar_addr  in  ADDR_WIDTH  read address
- ar_qos  in  4  read QoS
- ar_valid  in  1  read address valid
- ar_ready  out  1  read address ready
- r_data  out  DATA_WIDTH  read data
- r_resp  out  2  read response
- r_valid  out  1  read data valid
- r_ready  in  1  read data ready
- aw_addr  in  ADDR_WIDTH  write address
- aw_qos  in  4  write QoS
- aw_valid  in  1  write address valid
- aw_ready  out  1  write address ready
- w_data  in  DATA_WIDTH  write data
- w_strb  in  STRB_WIDTH  byte strobes
- w_valid  in  1  write data valid
- w_ready  out  1  write data ready
- b_resp  out  2  write response
- b_valid  out  1  write response valid
- b_ready  in  1  write response ready
- reg_idx  out  $clog2(REG_NUM)  word index to register bank
- reg_wr_en  out  1  one-cycle write strobe
- reg_wdata  out  DATA_WIDTH  write data
- reg_wstrb  out  STRB_WIDTH  byte enables
- reg_rd_en  out  1  one-cycle read strobe
- reg_rdata  in  DATA_WIDTH  read data, valid the cycle after reg_rd_en
- reg_err  in  1  bank error, aligned with reg_rdata or with reg_wr_en

Behaviour:
- Clocking and reset:
  - Single clock clk_i. Reset rst_ni is synchronous, active-low.
  - During reset: all outputs are 0, FSM goes to IDLE, all buffers are empty, and the round-robin pointer is set to "write last" so reads win the first tie.
  - Reset mid-transaction aborts the transaction silently. No response is issued.
- Capture buffers (AR, AW, W, one entry each):
  - ar_ready = ~ar_full. aw_ready = ~aw_full. w_ready = ~w_full. Readies are registered-state based, not combinational from valid.
  - AW and W are accepted independently, in either order or in the same cycle.
  - A buffer clears when its transaction is granted.
- FSM states: IDLE, WRITE, BRESP, READ, RCAP, RRESP.
- Arbitration in IDLE:
  - wr_rdy = aw_full & w_full. rd_rdy = ar_full.
  - If only one is ready, grant it.
  - If both are ready and QOS_EN=1, the higher qos wins.
  - If qos is equal or QOS_EN=0, grant the opposite of the last grant.
  - The last-grant pointer updates on every grant.
- Address decode: idx = addr[ADDR_WIDTH-1:ADDR_LSB]. Low ADDR_LSB bits are ignored, so unaligned addresses are treated as aligned. If idx >= REG_NUM, the access is out of range.
- Write path:
  - IDLE→WRITE: reg_wr_en=1 for exactly one cycle, unless out of range.
  - reg_idx, reg_wdata and reg_wstrb are driven from the buffers.
  - WRITE→BRESP: b_valid=1. b_resp=2'b10 if out of range or reg_err was sampled in WRITE, else 2'b00.
  - Hold until b_ready, then return to IDLE.
  - w_strb=0 is still a legal write: reg_wr_en pulses and the response is OKAY.
- Read path:
  - IDLE→READ: reg_rd_en=1 for one cycle, unless out of range.
  - READ→RCAP: sample reg_rdata and reg_err at the end of RCAP.
  - RCAP→RRESP: r_valid=1.
    - In range: r_data = sampled data. r_resp is 2'b10 if reg_err, else 2'b00.
    - Out of range: r_data=0, r_resp=2'b10.
  - Hold until r_ready, then return to IDLE.
- Latency, with the handshake at edge E0:
  - Write: reg_wr_en after E1; b_valid after E2.
  - Read: reg_rd_en after E1; r_valid after E3.
  - With ready tied high, a single write completes in 4 cycles and a single read in 5.
- Output hold: r_data, r_resp and b_resp are stable while their valid is high and ready is low.
- Pipelining during a response: new AR/AW/W may be captured during any state. They are not granted until IDLE.
- Exclusivity: reg_wr_en and reg_rd_en are never high together.

Test Plan:
- Write addr 0x8, data 0xA5A5_0001, strb 0xF, b_ready=1 → reg_wr_en one cycle with reg_idx=2; b_valid two cycles after the handshake; b_resp=00.
- W presented 3 cycles before AW (addr 0x4) → no reg_wr_en until AW is captured; then write to idx 1 with the earlier w_data.
- Read addr 0x40 with REG_NUM=16 → reg_rd_en stays 0; r_valid with r_resp=10 and r_data=0.
- AR and AW+W pending together:
  - with ar_qos=2, aw_qos=5 → write granted first, then read;
  - with equal qos after reset → read first, and the next tie goes to write.
- Read with r_ready held low for 5 cycles → r_valid and r_data stable; a new AR is captured (ar_ready then 0) and serviced only after the r handshake.
- Assert rst_ni=0 in state RCAP → next cycle r_valid=0, all readies=1, no response; a subsequent read of idx 0 returns reg_rdata.

Source files
------------

// File: rtl/axi4lite_reg_bridge_if.sv
// AXI4-Lite channel bundle between the interconnect and the register bridge.
// Only AR/R/AW/W/B payload and handshakes are carried; the clock stays outside.
interface axi4lite_reg_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] ar_addr;
   logic [3:0]            ar_qos;
   logic                  ar_valid;
   logic                  ar_ready;
   logic [DATA_WIDTH-1:0] r_data;
   logic [1:0]            r_resp;
   logic                  r_valid;
   logic                  r_ready;
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic [3:0]            aw_qos;
   logic                  aw_valid;
   logic                  aw_ready;
   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_WIDTH-1:0] w_strb;
   logic                  w_valid;
   logic                  w_ready;
   logic [1:0]            b_resp;
   logic                  b_valid;
   logic                  b_ready;

   modport slave (
      input  ar_addr, ar_qos, ar_valid, r_ready,
      input  aw_addr, aw_qos, aw_valid, w_data, w_strb, w_valid, b_ready,
      output ar_ready, r_data, r_resp, r_valid,
      output aw_ready, w_ready, b_resp, b_valid
   );

   modport master (
      output ar_addr, ar_qos, ar_valid, r_ready,
      output aw_addr, aw_qos, aw_valid, w_data, w_strb, w_valid, b_ready,
      input  ar_ready, r_data, r_resp, r_valid,
      input  aw_ready, w_ready, b_resp, b_valid
   );
endinterface

// File: rtl/axi4lite_reg_bridge.sv
// AXI4-Lite slave that turns single transactions into one-cycle register bank
// strobes, with one-deep AR/AW/W buffers and QoS + round-robin arbitration.
module axi4lite_reg_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 16,
   parameter int QOS_EN     = 1,
   localparam int STRB_WIDTH = DATA_WIDTH / 8,
   localparam int IDX_WIDTH  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   axi4lite_reg_bridge_if.slave  bus,
   output logic [IDX_WIDTH-1:0]  reg_idx,
   output logic                  reg_wr_en,
   output logic [DATA_WIDTH-1:0] reg_wdata,
   output logic [STRB_WIDTH-1:0] reg_wstrb,
   output logic                  reg_rd_en,
   input  logic [DATA_WIDTH-1:0] reg_rdata,
   input  logic                  reg_err
);
   localparam int ADDR_LSB = $clog2(STRB_WIDTH);
   localparam int WIDX_W   = ADDR_WIDTH - ADDR_LSB;

   typedef enum logic [2:0] {IDLE, WRITE, BRESP, READ, RCAP, RRESP} state_t;

   state_t                state_q, state_d;
   logic                  ar_full, aw_full, w_full;
   logic [WIDX_W-1:0]     ar_widx_q, aw_widx_q;
   logic [3:0]            ar_qos_q, aw_qos_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_WIDTH-1:0] w_strb_q;
   logic                  last_wr;
   logic                  oor_q;
   logic [DATA_WIDTH-1:0] r_data_q;
   logic [1:0]            r_resp_q, b_resp_q;
   logic                  wr_rdy, rd_rdy, grant_wr, grant_rd;
   logic                  ar_oor, aw_oor;
   logic                  unused_addr_lsbs;

   // Sub-word address bits are ignored: unaligned accesses hit the containing word.
   assign unused_addr_lsbs = ^{bus.ar_addr[ADDR_LSB-1:0], bus.aw_addr[ADDR_LSB-1:0]};

   assign wr_rdy = aw_full & w_full;
   assign rd_rdy = ar_full;
   assign ar_oor = ar_widx_q >= WIDX_W'(REG_NUM);
   assign aw_oor = aw_widx_q >= WIDX_W'(REG_NUM);

   assign bus.ar_ready = rst_ni & ~ar_full;
   assign bus.aw_ready = rst_ni & ~aw_full;
   assign bus.w_ready  = rst_ni & ~w_full;
   assign bus.r_valid  = (state_q == RRESP);
   assign bus.r_data   = r_data_q;
   assign bus.r_resp   = r_resp_q;
   assign bus.b_valid  = (state_q == BRESP);
   assign bus.b_resp   = b_resp_q;
   assign reg_wr_en    = (state_q == WRITE) & ~oor_q;
   assign reg_rd_en    = (state_q == READ) & ~oor_q;

   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (state_q == IDLE) begin
         if (wr_rdy && rd_rdy) begin
            // Equal QoS (or QoS disabled) alternates with the previous grant.
            if (QOS_EN != 0 && aw_qos_q != ar_qos_q) grant_wr = (aw_qos_q > ar_qos_q);
            else                                      grant_wr = ~last_wr;
            grant_rd = ~grant_wr;
         end else begin
            grant_wr = wr_rdy;
            grant_rd = rd_rdy;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (grant_wr) state_d = WRITE;
                  else if (grant_rd) state_d = READ;
         WRITE:   state_d = BRESP;
         BRESP:   if (bus.b_ready) state_d = IDLE;
         READ:    state_d = RCAP;
         RCAP:    state_d = RRESP;
         RRESP:   if (bus.r_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         ar_full   <= 1'b0;
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         ar_widx_q <= '0;
         aw_widx_q <= '0;
         ar_qos_q  <= '0;
         aw_qos_q  <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         last_wr   <= 1'b1;
         oor_q     <= 1'b0;
         reg_idx   <= '0;
         reg_wdata <= '0;
         reg_wstrb <= '0;
         r_data_q  <= '0;
         r_resp_q  <= 2'b00;
         b_resp_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         if (grant_rd) ar_full <= 1'b0;
         if (grant_wr) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
         end
         // Capture only into an empty buffer, so it never collides with a grant clear.
         if (bus.ar_valid && !ar_full) begin
            ar_full   <= 1'b1;
            ar_widx_q <= bus.ar_addr[ADDR_WIDTH-1:ADDR_LSB];
            ar_qos_q  <= bus.ar_qos;
         end
         if (bus.aw_valid && !aw_full) begin
            aw_full   <= 1'b1;
            aw_widx_q <= bus.aw_addr[ADDR_WIDTH-1:ADDR_LSB];
            aw_qos_q  <= bus.aw_qos;
         end
         if (bus.w_valid && !w_full) begin
            w_full   <= 1'b1;
            w_data_q <= bus.w_data;
            w_strb_q <= bus.w_strb;
         end
         if (grant_wr) begin
            last_wr   <= 1'b1;
            oor_q     <= aw_oor;
            reg_idx   <= IDX_WIDTH'(aw_widx_q);
            reg_wdata <= w_data_q;
            reg_wstrb <= w_strb_q;
         end else if (grant_rd) begin
            last_wr <= 1'b0;
            oor_q   <= ar_oor;
            reg_idx <= IDX_WIDTH'(ar_widx_q);
         end
         if (state_q == WRITE) b_resp_q <= (oor_q | reg_err) ? 2'b10 : 2'b00;
         if (state_q == RCAP) begin
            r_data_q <= oor_q ? '0 : reg_rdata;
            r_resp_q <= (oor_q | reg_err) ? 2'b10 : 2'b00;
         end
      end
   end
endmodule

// File: tb/tb_axi4lite_reg_bridge.sv
// Random and directed traffic against a word-array reference model of the
// register file, plus a small bank model that answers the strobe bus.
module tb_axi4lite_reg_bridge;
   localparam int NREG = 16;
   localparam int ERR_IDX = 13;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   axi4lite_reg_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   logic [3:0]  reg_idx;
   logic        reg_wr_en, reg_rd_en, reg_err;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_wstrb;
   logic [31:0] reg_rdata = '0;

   axi4lite_reg_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUM(NREG), .QOS_EN(1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus),
      .reg_idx(reg_idx), .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
      .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata), .reg_err(reg_err)
   );

   // Bank: word ERR_IDX flags an error on every access; rdata is garbage unless just read.
   logic [31:0] bank [NREG] = '{default: '0};
   logic        rd_err_q = 1'b0;
   always @(posedge clk_i) begin
      if (reg_wr_en)
         for (int b = 0; b < 4; b++)
            if (reg_wstrb[b]) bank[reg_idx][8*b +: 8] <= reg_wdata[8*b +: 8];
      reg_rdata <= reg_rd_en ? bank[reg_idx] : 32'hDEAD_BEEF;
      rd_err_q  <= reg_rd_en && (reg_idx == 4'(ERR_IDX));
   end
   assign reg_err = rd_err_q | (reg_wr_en && reg_idx == 4'(ERR_IDX));

   int wr_cnt = 0, rd_cnt = 0, excl_err = 0;
   int order_q[$];
   always @(negedge clk_i) begin
      if (reg_wr_en) begin wr_cnt++; order_q.push_back(1); end
      if (reg_rd_en) begin rd_cnt++; order_q.push_back(2); end
      if (reg_wr_en && reg_rd_en) excl_err++;
   end

   logic [31:0] mem [NREG];
   int exp_wr = 0, exp_rd = 0;
   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
      for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = nw[8*b +: 8];
      return old;
   endfunction

   function automatic logic [1:0] exp_resp(input int idx);
      return (idx >= NREG || idx == ERR_IDX) ? 2'b10 : 2'b00;
   endfunction

   task automatic do_reset(input int n);
      rst_ni = 1'b0;
      repeat (n) tick();
      rst_ni = 1'b1;
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, input int w_lead);
      int aw_at, w_at, cyc, idx;
      bit aw_done, w_done, aw_hs, w_hs, early, done, hold_err, have_held;
      logic [1:0] resp, held;
      aw_at = (w_lead > 0) ? w_lead : 0;
      w_at  = (w_lead < 0) ? -w_lead : 0;
      aw_done = 0; w_done = 0; early = 0; cyc = 0; resp = 2'bxx; held = 2'b00;
      bus.aw_qos = 4'($urandom);
      while (!(aw_done && w_done) && cyc < 100) begin
         if (!aw_done && cyc >= aw_at) begin bus.aw_valid = 1'b1; bus.aw_addr = addr; end
         if (!w_done && cyc >= w_at) begin bus.w_valid = 1'b1; bus.w_data = data; bus.w_strb = strb; end
         @(negedge clk_i);
         if (w_done && !aw_done && reg_wr_en) early = 1;
         aw_hs = bus.aw_valid && bus.aw_ready;
         w_hs  = bus.w_valid && bus.w_ready;
         tick();
         if (aw_hs) begin aw_done = 1; bus.aw_valid = 1'b0; end
         if (w_hs) begin w_done = 1; bus.w_valid = 1'b0; end
         cyc++;
      end
      if (!(aw_done && w_done)) chk("wr_hs_timeout", 0, 1);
      chk("wr_no_strobe_before_aw", early, 0);
      done = 0; hold_err = 0; have_held = 0; cyc = 0;
      while (!done && cyc < 100) begin
         bus.b_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk_i);
         if (bus.b_valid) begin
            if (have_held && bus.b_resp !== held) hold_err = 1;
            if (bus.b_ready) begin resp = bus.b_resp; done = 1; end
            else begin held = bus.b_resp; have_held = 1; end
         end
         tick();
         cyc++;
      end
      bus.b_ready = 1'b0;
      if (!done) chk("b_timeout", 0, 1);
      idx = int'(addr >> 2);
      if (idx < NREG) begin mem[idx] = merge(mem[idx], data, strb); exp_wr++; end
      chk("b_resp", resp, exp_resp(idx));
      chk("b_hold", hold_err, 0);
   endtask

   task automatic axi_read(input logic [31:0] addr);
      int cyc, idx;
      bit hs, done, hold_err, have_held;
      logic [31:0] d, hd, exp_d;
      logic [1:0] rr, hr;
      d = 'x; rr = 'x; hd = '0; hr = '0;
      bus.ar_addr = addr; bus.ar_qos = 4'($urandom); bus.ar_valid = 1'b1;
      hs = 0; cyc = 0;
      while (!hs && cyc < 100) begin
         @(negedge clk_i);
         hs = bus.ar_ready;
         tick();
         cyc++;
      end
      bus.ar_valid = 1'b0;
      if (!hs) chk("ar_timeout", 0, 1);
      done = 0; hold_err = 0; have_held = 0; cyc = 0;
      while (!done && cyc < 100) begin
         bus.r_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk_i);
         if (bus.r_valid) begin
            if (have_held && (bus.r_data !== hd || bus.r_resp !== hr)) hold_err = 1;
            if (bus.r_ready) begin d = bus.r_data; rr = bus.r_resp; done = 1; end
            else begin hd = bus.r_data; hr = bus.r_resp; have_held = 1; end
         end
         tick();
         cyc++;
      end
      bus.r_ready = 1'b0;
      if (!done) chk("r_timeout", 0, 1);
      idx = int'(addr >> 2);
      if (idx < NREG) begin exp_d = mem[idx]; exp_rd++; end
      else exp_d = '0;
      chk("r_data", d, exp_d);
      chk("r_resp", rr, exp_resp(idx));
      chk("r_hold", hold_err, 0);
   endtask

   // AR and AW+W land in the same cycle; exp_first: 1 = write strobe first, 2 = read first.
   task automatic pair(input int ri, input int wi, input logic [3:0] rq, input logic [3:0] wq,
                       input int exp_first, input string tag);
      logic [31:0] wd, rd;
      logic [1:0] rr, br;
      bit got_r, got_b;
      wd = $urandom; rd = 'x; rr = 'x; br = 'x; got_r = 0; got_b = 0;
      order_q.delete();
      bus.ar_addr = 32'(ri * 4); bus.ar_qos = rq; bus.ar_valid = 1'b1;
      bus.aw_addr = 32'(wi * 4); bus.aw_qos = wq; bus.aw_valid = 1'b1;
      bus.w_data = wd; bus.w_strb = 4'hF; bus.w_valid = 1'b1;
      bus.r_ready = 1'b1; bus.b_ready = 1'b1;
      @(negedge clk_i);
      chk({tag, "_accept"}, {bus.ar_ready, bus.aw_ready, bus.w_ready}, 3'b111);
      tick();
      bus.ar_valid = 1'b0; bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         if (bus.r_valid) begin rd = bus.r_data; rr = bus.r_resp; got_r = 1; end
         if (bus.b_valid) begin br = bus.b_resp; got_b = 1; end
         tick();
      end
      bus.r_ready = 1'b0; bus.b_ready = 1'b0;
      chk({tag, "_both_done"}, {got_r, got_b}, 2'b11);
      chk({tag, "_strobes"}, order_q.size(), 2);
      chk({tag, "_first"}, (order_q.size() > 0) ? order_q[0] : 0, exp_first);
      chk({tag, "_r_data"}, rd, mem[ri]);
      chk({tag, "_r_resp"}, rr, 2'b00);
      chk({tag, "_b_resp"}, br, 2'b00);
      mem[wi] = wd;
      exp_wr++; exp_rd++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1);
   end

   initial begin
      logic [31:0] d0;
      logic [1:0]  rr0;
      bit stable, hs, seen;
      int rd_mark, cyc;

      for (int i = 0; i < NREG; i++) mem[i] = '0;
      bus.ar_addr = '0; bus.ar_qos = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b0;
      bus.aw_addr = '0; bus.aw_qos = '0; bus.aw_valid = 1'b0;
      bus.w_data = '0; bus.w_strb = '0; bus.w_valid = 1'b0; bus.b_ready = 1'b0;

      // reset state
      rst_ni = 1'b0;
      repeat (3) tick();
      @(negedge clk_i);
      chk("rst_readies", {bus.ar_ready, bus.aw_ready, bus.w_ready}, 3'b000);
      chk("rst_valids", {bus.r_valid, bus.b_valid, reg_wr_en, reg_rd_en}, 4'b0000);
      chk("rst_outputs", {bus.r_data, bus.r_resp, bus.b_resp, reg_wdata}, '0);
      tick();
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("post_rst_readies", {bus.ar_ready, bus.aw_ready, bus.w_ready}, 3'b111);
      tick();

      // single write, exact latency
      bus.aw_addr = 32'h8; bus.aw_qos = 4'h0; bus.aw_valid = 1'b1;
      bus.w_data = 32'hA5A5_0001; bus.w_strb = 4'hF; bus.w_valid = 1'b1; bus.b_ready = 1'b1;
      @(negedge clk_i);
      chk("t1_ready", {bus.aw_ready, bus.w_ready}, 2'b11);
      tick();
      bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
      @(negedge clk_i);
      chk("t1_no_early_wr_en", reg_wr_en, 0);
      tick();
      @(negedge clk_i);
      chk("t1_wr_en", reg_wr_en, 1);
      chk("t1_idx", reg_idx, 2);
      chk("t1_wdata", reg_wdata, 32'hA5A5_0001);
      chk("t1_wstrb", reg_wstrb, 4'hF);
      tick();
      @(negedge clk_i);
      chk("t1_wr_en_one_cycle", reg_wr_en, 0);
      chk("t1_b_valid", bus.b_valid, 1);
      chk("t1_b_resp", bus.b_resp, 2'b00);
      tick();
      @(negedge clk_i);
      chk("t1_b_done", bus.b_valid, 0);
      tick();
      bus.b_ready = 1'b0;
      mem[2] = 32'hA5A5_0001; exp_wr++;

      // W three cycles ahead of AW, zero-strobe write, then readbacks
      axi_write(32'h4, 32'h1234_5678, 4'hF, 3);
      axi_read(32'h4);
      axi_write(32'h6, 32'hFFFF_FFFF, 4'h0, -1);
      axi_read(32'h5);
      axi_read(32'h8);

      // out of range read never strobes the bank
      rd_mark = rd_cnt;
      axi_read(32'h40);
      chk("t3_no_rd_strobe", rd_cnt - rd_mark, 0);
      axi_write(32'h44, 32'h0BAD_0BAD, 4'hF, 0);

      // arbitration
      do_reset(2);
      pair(5, 6, 4'd2, 4'd5, 1, "qos_wr_wins");
      pair(7, 8, 4'd5, 4'd2, 2, "qos_rd_wins");
      do_reset(2);
      pair(9, 10, 4'd7, 4'd7, 2, "tie_after_rst");
      axi_read(32'h0);
      pair(11, 12, 4'd3, 4'd3, 1, "tie_after_rd");

      // long r backpressure with a second AR buffered behind it
      bus.ar_addr = 32'hC; bus.ar_valid = 1'b1; bus.r_ready = 1'b0;
      @(negedge clk_i);
      tick();
      bus.ar_valid = 1'b0;
      seen = 0; cyc = 0;
      while (!seen && cyc < 20) begin
         @(negedge clk_i);
         seen = bus.r_valid;
         if (!seen) tick();
         cyc++;
      end
      chk("t5_r_valid", seen, 1);
      d0 = bus.r_data; rr0 = bus.r_resp;
      chk("t5_r_data", d0, mem[3]);
      tick();
      bus.ar_addr = 32'h10; bus.ar_valid = 1'b1;
      stable = 1; hs = 0; rd_mark = rd_cnt;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         if (!bus.r_valid || bus.r_data !== d0 || bus.r_resp !== rr0) stable = 0;
         if (bus.ar_valid && bus.ar_ready) hs = 1;
         tick();
         if (hs) bus.ar_valid = 1'b0;
      end
      @(negedge clk_i);
      chk("t5_r_stable", stable, 1);
      chk("t5_ar_captured", hs, 1);
      chk("t5_ar_ready_full", bus.ar_ready, 0);
      chk("t5_no_rd_strobe", rd_cnt - rd_mark, 0);
      tick();
      bus.r_ready = 1'b1;
      tick();
      seen = 0; cyc = 0;
      while (!seen && cyc < 20) begin
         @(negedge clk_i);
         seen = bus.r_valid;
         if (seen) d0 = bus.r_data;
         tick();
         cyc++;
      end
      bus.r_ready = 1'b0;
      chk("t5_second_r", seen, 1);
      chk("t5_second_r_data", d0, mem[4]);
      exp_rd += 2;

      // reset while in RCAP drops the read silently
      bus.ar_addr = 32'h0; bus.ar_valid = 1'b1; bus.r_ready = 1'b1;
      tick();
      bus.ar_valid = 1'b0;
      @(negedge clk_i);
      tick();
      @(negedge clk_i);
      chk("t6_rd_en", reg_rd_en, 1);
      tick();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("t6_r_valid_dropped", bus.r_valid, 0);
      chk("t6_readies", {bus.ar_ready, bus.aw_ready, bus.w_ready}, 3'b111);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         @(negedge clk_i);
         if (bus.r_valid || bus.b_valid) seen = 1;
      end
      chk("t6_no_response", seen, 0);
      tick();
      bus.r_ready = 1'b0;
      exp_rd++;
      axi_read(32'h0);

      // random traffic including unaligned and out of range addresses
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 1) == 0)
            axi_write(32'($urandom_range(0, 'h5F)), $urandom, 4'($urandom), $urandom_range(0, 4) - 2);
         else
            axi_read(32'($urandom_range(0, 'h5F)));
      end
      for (int i = 0; i < NREG; i++) axi_read(32'(i * 4));

      chk("strobe_exclusive", excl_err, 0);
      chk("wr_strobe_count", wr_cnt, exp_wr);
      chk("rd_strobe_count", rd_cnt, exp_rd);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
